ex2_mem_stage: RTL and testbench

EX2_MEM_STAGE -- requirements
Module: ex2_mem_stage

---
 rtl/ex2_mem_pkg.sv | 14 +
 rtl/ex2_mem_stage_load_use_detect.sv | 22 ++
 rtl/ex2_mem_stage.sv | 138 +++++++++++++
 tb/tb_ex2_mem_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ex2_mem_pkg.sv
// Shared definitions for the EX2/MEM pipeline stage: address widths,
// the default load-use penalty and the stall FSM encoding.
package ex2_mem_pkg;

  localparam int REG_AW                    = 5;
  localparam int CSR_AW                    = 12;
  localparam int DEFAULT_LOAD_STALL_CYCLES = 2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LSTALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/ex2_mem_stage_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX1 and the
// source registers of the instruction currently in ID.
module ex2_mem_stage_load_use_detect
  import ex2_mem_pkg::*;
(
  input  logic              ex1_valid,
  input  logic              ex1_mem_read,
  input  logic [REG_AW-1:0] ex1_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hazard
);

  logic rd_nonzero;
  logic rd_matches;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign rd_nonzero = (ex1_rd != '0);
  assign rd_matches = (ex1_rd == id_rs1) || (ex1_rd == id_rs2);
  assign hazard     = ex1_valid && ex1_mem_read && rd_nonzero && rd_matches;

endmodule

// File: rtl/ex2_mem_stage.sv
// EX2/MEM pipeline register plus the load-use stall controller.
// The register captures EX1 every cycle unless the data memory is busy;
// the FSM holds the front end for LOAD_STALL_CYCLES cycles after a load
// whose destination is consumed by the instruction waiting in ID.
module ex2_mem_stage
  import ex2_mem_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int LOAD_STALL_CYCLES = DEFAULT_LOAD_STALL_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex1_valid,
  input  logic [REG_AW-1:0] ex1_RegWriteAddr,
  input  logic              ex1_RegWrite,
  input  logic              ex1_MemRead,
  input  logic              ex1_CSRR,
  input  logic [CSR_AW-1:0] ex1_CSRR_Addr,
  input  logic [XLEN-1:0]   ex1_result,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              mem_busy,
  input  logic              flush,
  output logic              MEM_valid,
  output logic              MEM_RegWrite,
  output logic              MEM_MemRead,
  output logic              MEM_CSRR,
  output logic [REG_AW-1:0] MEM_RegWriteAddr,
  output logic [CSR_AW-1:0] MEM_CSRR_Addr,
  output logic [XLEN-1:0]   MEM_result,
  output logic              stall_front,
  output logic              bubble_ex1
);

  // The counter only ever holds values up to LOAD_STALL_CYCLES-1.
  localparam int CNT_W      = (LOAD_STALL_CYCLES > 2) ? $clog2(LOAD_STALL_CYCLES) : 1;
  // With a single-cycle penalty the detecting cycle is the whole stall.
  localparam bit USE_LSTALL = (LOAD_STALL_CYCLES > 1);

  stall_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             capture_valid;

  ex2_mem_stage_load_use_detect u_load_use_detect (
    .ex1_valid    (ex1_valid),
    .ex1_mem_read (ex1_MemRead),
    .ex1_rd       (ex1_RegWriteAddr),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .hazard       (hazard)
  );

  // A flushed instruction enters the stage as a killed entry.
  assign capture_valid = ex1_valid && !flush;

  // Pipeline register: capture EX1 unless memory is busy; killed entries carry no control.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      MEM_valid        <= 1'b0;
      MEM_RegWrite     <= 1'b0;
      MEM_MemRead      <= 1'b0;
      MEM_CSRR         <= 1'b0;
      MEM_RegWriteAddr <= '0;
      MEM_CSRR_Addr    <= '0;
      MEM_result       <= '0;
    end else if (!mem_busy) begin
      MEM_valid        <= capture_valid;
      MEM_RegWrite     <= capture_valid && ex1_RegWrite;
      MEM_MemRead      <= capture_valid && ex1_MemRead;
      MEM_CSRR         <= capture_valid && ex1_CSRR;
      MEM_RegWriteAddr <= ex1_RegWriteAddr;
      MEM_CSRR_Addr    <= ex1_CSRR_Addr;
      MEM_result       <= ex1_result;
    end
  end

  // Stall FSM state and remaining-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall outputs. In LSTALL the counter holds the stall
  // cycles still owed including the current one; the detecting cycle in RUN
  // is the first stall cycle, so LSTALL is entered with LOAD_STALL_CYCLES-1.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_front = 1'b0;
    bubble_ex1  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          stall_front = 1'b1;
        end else if (hazard && !flush) begin
          stall_front = 1'b1;
          bubble_ex1  = 1'b1;
          if (USE_LSTALL) begin
            state_d = ST_LSTALL;
            cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
          end
        end
      end
      ST_LSTALL: begin
        stall_front = 1'b1;
        if (!mem_busy) begin
          bubble_ex1 = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // A mispredict squashes the load and its consumer, so any stall is abandoned.
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_ex2_mem_stage.sv
// Scoreboard bench for ex2_mem_stage: each directed vector pushes its
// hand-computed expected outputs; a monitor pops and compares on negedge.
module tb_ex2_mem_stage;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [4:0]  wa;
    logic        rw;
    logic        mr;
    logic        cr;
    logic [11:0] ca;
    logic [31:0] res;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy;
    logic        fl;
  } stim_t;

  typedef struct packed {
    logic        sf;
    logic        bub;
    logic        mv;
    logic        mrw;
    logic        mmr;
    logic        mcr;
    logic [4:0]  ma;
    logic [11:0] mca;
    logic [31:0] mres;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ex1_valid;
  logic [4:0]  ex1_RegWriteAddr;
  logic        ex1_RegWrite;
  logic        ex1_MemRead;
  logic        ex1_CSRR;
  logic [11:0] ex1_CSRR_Addr;
  logic [31:0] ex1_result;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        mem_busy;
  logic        flush;
  logic        MEM_valid;
  logic        MEM_RegWrite;
  logic        MEM_MemRead;
  logic        MEM_CSRR;
  logic [4:0]  MEM_RegWriteAddr;
  logic [11:0] MEM_CSRR_Addr;
  logic [31:0] MEM_result;
  logic        stall_front;
  logic        bubble_ex1;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  ex2_mem_stage #(.XLEN(32), .LOAD_STALL_CYCLES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex1_valid        (ex1_valid),
    .ex1_RegWriteAddr (ex1_RegWriteAddr),
    .ex1_RegWrite     (ex1_RegWrite),
    .ex1_MemRead      (ex1_MemRead),
    .ex1_CSRR         (ex1_CSRR),
    .ex1_CSRR_Addr    (ex1_CSRR_Addr),
    .ex1_result       (ex1_result),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .mem_busy         (mem_busy),
    .flush            (flush),
    .MEM_valid        (MEM_valid),
    .MEM_RegWrite     (MEM_RegWrite),
    .MEM_MemRead      (MEM_MemRead),
    .MEM_CSRR         (MEM_CSRR),
    .MEM_RegWriteAddr (MEM_RegWriteAddr),
    .MEM_CSRR_Addr    (MEM_CSRR_Addr),
    .MEM_result       (MEM_result),
    .stall_front      (stall_front),
    .bubble_ex1       (bubble_ex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int vec, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, vec, act, exp);
    end
  endtask

  function automatic stim_t S(input logic rst, input logic v, input logic [4:0] wa,
                              input logic rw, input logic mr, input logic cr,
                              input logic [11:0] ca, input logic [31:0] res,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic busy, input logic fl);
    S = '{rst, v, wa, rw, mr, cr, ca, res, rs1, rs2, busy, fl};
  endfunction

  function automatic exp_t X(input logic sf, input logic bub, input logic mv,
                             input logic mrw, input logic mmr, input logic mcr,
                             input logic [4:0] ma, input logic [11:0] mca,
                             input logic [31:0] mres);
    X = '{sf, bub, mv, mrw, mmr, mcr, ma, mca, mres};
  endfunction

  // Drive one cycle of inputs just after the rising edge; queue what the
  // outputs must look like at the following falling edge.
  task automatic step(input stim_t s, input exp_t e, input bit chk);
    @(posedge clk);
    #1;
    reset            = s.rst;
    ex1_valid        = s.v;
    ex1_RegWriteAddr = s.wa;
    ex1_RegWrite     = s.rw;
    ex1_MemRead      = s.mr;
    ex1_CSRR         = s.cr;
    ex1_CSRR_Addr    = s.ca;
    ex1_result       = s.res;
    id_rs1           = s.rs1;
    id_rs2           = s.rs2;
    mem_busy         = s.busy;
    flush            = s.fl;
    if (chk) begin
      sb_q.push_back(e);
      n_push++;
    end
  endtask

  // Monitor: compare every queued expectation against the sampled outputs.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_pop++;
      check("stall_front",      n_pop, 32'(stall_front),      32'(e.sf));
      check("bubble_ex1",       n_pop, 32'(bubble_ex1),       32'(e.bub));
      check("MEM_valid",        n_pop, 32'(MEM_valid),        32'(e.mv));
      check("MEM_RegWrite",     n_pop, 32'(MEM_RegWrite),     32'(e.mrw));
      check("MEM_MemRead",      n_pop, 32'(MEM_MemRead),      32'(e.mmr));
      check("MEM_CSRR",         n_pop, 32'(MEM_CSRR),         32'(e.mcr));
      check("MEM_RegWriteAddr", n_pop, 32'(MEM_RegWriteAddr), 32'(e.ma));
      check("MEM_CSRR_Addr",    n_pop, 32'(MEM_CSRR_Addr),    32'(e.mca));
      check("MEM_result",       n_pop, MEM_result,            e.mres);
    end
  end

  initial begin
    int guard;
    stim_t idle;
    exp_t  e0;
    idle = S(0, 0, 0, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 0);
    e0   = X(0, 0, 0, 0, 0, 0, 0, 12'h000, 32'h0);

    reset = 1'b1; ex1_valid = 1'b0; ex1_RegWriteAddr = '0; ex1_RegWrite = 1'b0;
    ex1_MemRead = 1'b0; ex1_CSRR = 1'b0; ex1_CSRR_Addr = '0; ex1_result = '0;
    id_rs1 = '0; id_rs2 = '0; mem_busy = 1'b0; flush = 1'b0;

    // Reset state
    step(S(1, 0, 0, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 0), e0, 0);
    step(S(1, 0, 0, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, 0), e0, 1);
    step(idle, e0, 1);

    // Plain capture with CSR read, visible one cycle later
    step(S(0, 1, 5, 1, 0, 1, 12'h305, 32'hDEADBEEF, 0, 0, 0, 0), e0, 1);
    step(idle, X(0, 0, 1, 1, 0, 1, 5, 12'h305, 32'hDEADBEEF), 1);

    // Load x7, consumer uses rs2=7: stall exactly two cycles
    step(S(0, 1, 7, 1, 1, 0, 12'h000, 32'h1000, 3, 7, 0, 0), X(1, 1, 0, 0, 0, 0, 0, 12'h000, 32'h0), 1);
    step(S(0, 0, 0, 0, 0, 0, 12'h000, 32'h0, 3, 7, 0, 0), X(1, 1, 1, 1, 1, 0, 7, 12'h000, 32'h1000), 1);
    step(idle, e0, 1);

    // Load into x0 with rs1=0: no stall
    step(S(0, 1, 0, 1, 1, 0, 12'h000, 32'h55, 0, 4, 0, 0), e0, 1);
    step(idle, X(0, 0, 1, 1, 1, 0, 0, 12'h000, 32'h55), 1);

    // Load-use with mem_busy for three cycles mid-stall: five stall cycles, MEM held
    step(S(0, 1, 9, 1, 1, 0, 12'h000, 32'hA5A5, 9, 0, 0, 0), X(1, 1, 0, 0, 0, 0, 0, 12'h000, 32'h0), 1);
    step(S(0, 0, 0, 0, 0, 0, 12'h000, 32'h0, 9, 0, 1, 0), X(1, 0, 1, 1, 1, 0, 9, 12'h000, 32'hA5A5), 1);
    step(S(0, 0, 0, 0, 0, 0, 12'h000, 32'h0, 9, 0, 1, 0), X(1, 0, 1, 1, 1, 0, 9, 12'h000, 32'hA5A5), 1);
    step(S(0, 0, 0, 0, 0, 0, 12'h000, 32'h0, 9, 0, 1, 0), X(1, 0, 1, 1, 1, 0, 9, 12'h000, 32'hA5A5), 1);
    step(S(0, 0, 0, 0, 0, 0, 12'h000, 32'h0, 9, 0, 0, 0), X(1, 1, 1, 1, 1, 0, 9, 12'h000, 32'hA5A5), 1);
    step(idle, e0, 1);

    // Flush together with a load-use hazard: killed entry, no stall
    step(S(0, 1, 6, 1, 1, 0, 12'h000, 32'h77, 6, 0, 0, 1), e0, 1);
    step(idle, X(0, 0, 0, 0, 0, 0, 6, 12'h000, 32'h77), 1);

    // Reset in the first LSTALL cycle aborts the stall
    step(S(0, 1, 8, 1, 1, 0, 12'h000, 32'h12, 0, 8, 0, 0), X(1, 1, 0, 0, 0, 0, 0, 12'h000, 32'h0), 1);
    step(S(1, 0, 0, 0, 0, 0, 12'h000, 32'h0, 0, 8, 0, 0), X(1, 1, 1, 1, 1, 0, 8, 12'h000, 32'h12), 1);
    step(idle, e0, 1);

    // mem_busy in RUN: front stalled without bubble, capture suppressed
    step(S(0, 1, 3, 1, 0, 0, 12'h000, 32'h33, 0, 0, 1, 0), X(1, 0, 0, 0, 0, 0, 0, 12'h000, 32'h0), 1);
    step(idle, e0, 1);
    step(idle, e0, 1);

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    check("scoreboard_drained", 0, 32'(n_pop), 32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
